lw_axi_reg_sequencer: RTL and testbench
=======================================

# lw_axi_reg_sequencer

Shares the lightweight AXI slave path into `hps_fpga_debug` between two simple register-access requesters. Arbitrates round-robin, converts each accepted request into a single-beat 32-bit AXI3 read or write, and returns the data/response to the owning requester. One transaction is outstanding at a time. A timeout recovers from a silent slave.

## Interface
- `ID_BASE`, 12'h000: AXI ID for all transactions; bit 0 is replaced by the requester index.
- `TIMEOUT`, 1000: cycles to wait for R or B before giving up; 0 disables the timeout; 16-bit counter.
- `clk`  in  1  single clock for all logic.
- `reset`  in  1  synchronous, active-high reset.
- `reqN__valid` (N=0,1)  in  1  request pending; held until `reqN_ack`.
- `reqN__write`  in  1  1 = write, 0 = read.
- `reqN__addr`  in  32  byte address; bits [1:0] are forced to 0 on the bus.
- `reqN__data`  in  32  write data.
- `reqN__strb`  in  4  write byte strobes.
- `reqN_ack`  out  1  one-cycle grant; the request is captured on this edge.
- `respN__valid`  out  1  one-cycle response pulse; no back-pressure.
- `respN__data`  out  32  read data; 0 for writes.
- `respN__resp`  out  2  AXI resp, or 2'b11 on timeout.
- `ar__*`, `aw__*`  out  (AXI3 address fields)  `len`=0, `size`=2, `burst`=1, `id`=ID_BASE|idx; all other fields 0.
- `arready`, `awready`, `wready`  in  1  AXI ready signals.
- `w__valid`/`id`/`data`/`strb`/`last`  out  write data channel; `last`=1.
- `r__*`, `b__*`  in  AXI read-data and write-response channels.
- `rready`, `bready`  out  1  response-channel ready.
- `status__busy`  out  1  state ≠ IDLE.
- `status__id_error`  out  1  sticky: an R/B beat was taken with an unexpected ID.
- `status__timeouts`  out  8  saturating timeout count.

## Operation
- State machine states: IDLE, RD_ADDR, RD_DATA, WR_ADDR_DATA, WR_RESP, RESPOND, DRAIN.
- **IDLE, arbitration:** `reqN_ack` is combinational from valids.
  - Single valid: that requester is granted.
  - Both valid: the requester not granted last time wins. `last_grant` resets to 1, so requester 0 wins first.
  - Grant captures index, write flag, addr, data and strb; goes to RD_ADDR or WR_ADDR_DATA.
- **RD_ADDR:** `ar__valid`=1 until `arready`, then RD_DATA.
- **RD_DATA:** `rready`=1. On `r__valid`, capture data/resp and go to RESPOND.
- **WR_ADDR_DATA:** `aw__valid` and `w__valid` are both asserted on entry. Each drops independently on its ready. When both have handshaken (including the same cycle), go to WR_RESP.
- **WR_RESP:** `bready`=1. On `b__valid`, capture resp and go to RESPOND.
- **RESPOND:** `resp<idx>__valid`=1 for exactly one cycle, then IDLE. No grant is made in this cycle.
- **ID check:** an R/B beat whose ID ≠ ID_BASE|idx is still consumed as the response and sets `status__id_error`.
- **Timeout:**
  - A counter clears on entering RD_DATA or WR_RESP and increments each cycle in those states.
  - On reaching TIMEOUT: respond with resp=2'b11, data=0, increment `status__timeouts` (saturating at 255), then go to DRAIN.
  - DRAIN holds `rready`/`bready` (per the captured write flag) until one beat arrives, discards it, then returns to IDLE.
  - Timeout is not applied to the address/data channels.
- **Reset:**
  - Every output and state register clears to 0, state to IDLE, `last_grant` to 1.
  - Reset mid-transaction abandons the bus transaction; the system-level reset is responsible for the slave.

## Timing
- Request captured at the edge ending the `reqN_ack` cycle T. AXI valids are registered: high from T+1.
- Minimum read latency: `arready` at T+1, `r__valid` at T+2, `resp__valid` at T+3.
- Minimum write latency: aw/w ready at T+1, `b__valid` at T+2, `resp__valid` at T+3.
- Back-to-back: the next grant is no earlier than the cycle after RESPOND, giving a 4-cycle minimum issue period.
- `respN__data`/`resp` are valid only while `respN__valid`=1, and hold until the next response.

## Test plan
- **Single read:** req0 read addr 0x104; slave returns 0xDEADBEEF/OKAY with zero wait.
  - ar addr=0x104, id=ID_BASE|0, len=0, size=2.
  - resp0 valid at T+3 with data 0xDEADBEEF, resp 0; resp1 never pulses.
- **Write with skewed readies:** req1 write 0x8=0x12345678, strb 0xF; `wready` 3 cycles before `awready`.
  - w__valid drops after its handshake; aw__valid persists; bready only after both.
  - resp1 pulses with resp 0, data 0.
- **Contention:** both requesters hold valid for 4 transactions.
  - Grants alternate 0,1,0,1; each ack is one cycle; no ack during a busy period.
- **Timeout:** TIMEOUT=8; read with the slave never asserting `r__valid`.
  - resp0 valid with resp=2'b11 exactly 8 cycles after RD_DATA entry; status__timeouts=1.
  - A late `r__valid` is consumed in DRAIN with no resp pulse; the next request is granted only afterwards.
- **ID error and reset:** R beat with id 0x7FF sets `status__id_error`, and the data is still returned.
  - Asserting `reset` during WR_ADDR_DATA clears all valids, status and state the next cycle; a fresh read then completes normally.

Source files
------------

// File: rtl/lw_axi_reg_sequencer.sv
// Two-requester register-access sequencer onto a lightweight AXI3 slave port.
// Round-robin grant, single outstanding single-beat transfer, R/B timeout with drain.
module lw_axi_reg_sequencer #(
    parameter logic [11:0] ID_BASE = 12'h000,
    parameter int unsigned TIMEOUT = 1000
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        req0__valid,
    input  logic        req0__write,
    input  logic [31:0] req0__addr,
    input  logic [31:0] req0__data,
    input  logic [3:0]  req0__strb,
    output logic        req0_ack,
    input  logic        req1__valid,
    input  logic        req1__write,
    input  logic [31:0] req1__addr,
    input  logic [31:0] req1__data,
    input  logic [3:0]  req1__strb,
    output logic        req1_ack,

    output logic        resp0__valid,
    output logic [31:0] resp0__data,
    output logic [1:0]  resp0__resp,
    output logic        resp1__valid,
    output logic [31:0] resp1__data,
    output logic [1:0]  resp1__resp,

    output logic        ar__valid,
    output logic [31:0] ar__addr,
    output logic [11:0] ar__id,
    output logic [3:0]  ar__len,
    output logic [2:0]  ar__size,
    output logic [1:0]  ar__burst,
    output logic [1:0]  ar__lock,
    output logic [3:0]  ar__cache,
    output logic [2:0]  ar__prot,
    input  logic        arready,

    output logic        aw__valid,
    output logic [31:0] aw__addr,
    output logic [11:0] aw__id,
    output logic [3:0]  aw__len,
    output logic [2:0]  aw__size,
    output logic [1:0]  aw__burst,
    output logic [1:0]  aw__lock,
    output logic [3:0]  aw__cache,
    output logic [2:0]  aw__prot,
    input  logic        awready,

    output logic        w__valid,
    output logic [11:0] w__id,
    output logic [31:0] w__data,
    output logic [3:0]  w__strb,
    output logic        w__last,
    input  logic        wready,

    input  logic        r__valid,
    input  logic [11:0] r__id,
    input  logic [31:0] r__data,
    input  logic [1:0]  r__resp,
    input  logic        r__last,
    output logic        rready,

    input  logic        b__valid,
    input  logic [11:0] b__id,
    input  logic [1:0]  b__resp,
    output logic        bready,

    output logic        status__busy,
    output logic        status__id_error,
    output logic [7:0]  status__timeouts
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_ADDR,
        S_RD_DATA,
        S_WR_ADDR_DATA,
        S_WR_RESP,
        S_RESPOND,
        S_DRAIN
    } state_e;

    localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

    state_e      state_q, state_d;
    logic        idx_q, write_q, last_grant_q, to_q;
    logic [31:0] addr_q, wdata_q;
    logic [3:0]  strb_q;
    logic        ar_valid_q, aw_valid_q, w_valid_q;
    logic [15:0] cnt_q;
    logic        id_err_q;
    logic [7:0]  timeouts_q;
    logic [31:0] r0_data_q, r1_data_q;
    logic [1:0]  r0_resp_q, r1_resp_q;

    logic        grant_any, grant_idx, grant_write, grant_fire;
    logic        in_wait, beat, timeout_hit, capture;
    logic        aw_done, w_done;
    logic [11:0] exp_id, beat_id;
    logic [31:0] cap_data;
    logic [1:0]  cap_resp;
    logic        unused_r_last;

    assign unused_r_last = r__last;

    // Both requesting: the one not served last time wins.
    assign grant_any   = req0__valid || req1__valid;
    assign grant_idx   = (req0__valid && req1__valid) ? ~last_grant_q : req1__valid;
    assign grant_write = grant_idx ? req1__write : req0__write;
    assign grant_fire  = (state_q == S_IDLE) && grant_any && !reset;

    assign exp_id      = {ID_BASE[11:1], idx_q};
    assign in_wait     = (state_q == S_RD_DATA) || (state_q == S_WR_RESP);
    assign beat        = ((state_q == S_RD_DATA) && r__valid) || ((state_q == S_WR_RESP) && b__valid);
    assign beat_id     = (state_q == S_RD_DATA) ? r__id : b__id;
    // A beat arriving on the last allowed cycle wins over the timeout.
    assign timeout_hit = (TIMEOUT != 0) && in_wait && !beat && (cnt_q == TO_LAST);
    assign capture     = beat || timeout_hit;
    assign cap_data    = (timeout_hit || write_q) ? 32'd0 : r__data;
    assign cap_resp    = timeout_hit ? 2'b11 : (write_q ? b__resp : r__resp);

    assign aw_done     = !aw_valid_q || awready;
    assign w_done      = !w_valid_q || wready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:         if (grant_fire) state_d = grant_write ? S_WR_ADDR_DATA : S_RD_ADDR;
            S_RD_ADDR:      if (arready) state_d = S_RD_DATA;
            S_RD_DATA:      if (capture) state_d = S_RESPOND;
            S_WR_ADDR_DATA: if (aw_done && w_done) state_d = S_WR_RESP;
            S_WR_RESP:      if (capture) state_d = S_RESPOND;
            S_RESPOND:      state_d = to_q ? S_DRAIN : S_IDLE;
            S_DRAIN:        if (write_q ? b__valid : r__valid) state_d = S_IDLE;
            default:        state_d = S_IDLE;
        endcase
    end

    always_comb begin
        req0_ack     = 1'b0;
        req1_ack     = 1'b0;
        resp0__valid = 1'b0;
        resp1__valid = 1'b0;
        rready       = 1'b0;
        bready       = 1'b0;
        status__busy = (state_q != S_IDLE);
        if (grant_fire) begin
            req0_ack = !grant_idx;
            req1_ack = grant_idx;
        end
        if (state_q == S_RESPOND) begin
            resp0__valid = !idx_q;
            resp1__valid = idx_q;
        end
        rready = (state_q == S_RD_DATA) || ((state_q == S_DRAIN) && !write_q);
        bready = (state_q == S_WR_RESP) || ((state_q == S_DRAIN) && write_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            idx_q        <= 1'b0;
            write_q      <= 1'b0;
            last_grant_q <= 1'b1;
            to_q         <= 1'b0;
            addr_q       <= 32'd0;
            wdata_q      <= 32'd0;
            strb_q       <= 4'd0;
            ar_valid_q   <= 1'b0;
            aw_valid_q   <= 1'b0;
            w_valid_q    <= 1'b0;
            cnt_q        <= 16'd0;
            id_err_q     <= 1'b0;
            timeouts_q   <= 8'd0;
            r0_data_q    <= 32'd0;
            r0_resp_q    <= 2'd0;
            r1_data_q    <= 32'd0;
            r1_resp_q    <= 2'd0;
        end else begin
            if (grant_fire) begin
                idx_q        <= grant_idx;
                write_q      <= grant_write;
                last_grant_q <= grant_idx;
                to_q         <= 1'b0;
                addr_q       <= grant_idx ? req1__addr : req0__addr;
                wdata_q      <= grant_idx ? req1__data : req0__data;
                strb_q       <= grant_idx ? req1__strb : req0__strb;
            end
            ar_valid_q <= (state_d == S_RD_ADDR);
            if (grant_fire && grant_write) begin
                aw_valid_q <= 1'b1;
                w_valid_q  <= 1'b1;
            end else begin
                if (awready) aw_valid_q <= 1'b0;
                if (wready)  w_valid_q  <= 1'b0;
            end
            cnt_q <= in_wait ? cnt_q + 16'd1 : 16'd0;
            if (beat && (beat_id != exp_id)) id_err_q <= 1'b1;
            if (timeout_hit) begin
                to_q <= 1'b1;
                if (timeouts_q != 8'hFF) timeouts_q <= timeouts_q + 8'd1;
            end
            if (capture) begin
                if (idx_q) begin
                    r1_data_q <= cap_data;
                    r1_resp_q <= cap_resp;
                end else begin
                    r0_data_q <= cap_data;
                    r0_resp_q <= cap_resp;
                end
            end
        end
    end

    assign resp0__data      = r0_data_q;
    assign resp0__resp      = r0_resp_q;
    assign resp1__data      = r1_data_q;
    assign resp1__resp      = r1_resp_q;

    assign ar__valid        = ar_valid_q;
    assign ar__addr         = {addr_q[31:2], 2'b00};
    assign ar__id           = exp_id;
    assign ar__len          = 4'd0;
    assign ar__size         = 3'd2;
    assign ar__burst        = 2'd1;
    assign ar__lock         = 2'd0;
    assign ar__cache        = 4'd0;
    assign ar__prot         = 3'd0;

    assign aw__valid        = aw_valid_q;
    assign aw__addr         = {addr_q[31:2], 2'b00};
    assign aw__id           = exp_id;
    assign aw__len          = 4'd0;
    assign aw__size         = 3'd2;
    assign aw__burst        = 2'd1;
    assign aw__lock         = 2'd0;
    assign aw__cache        = 4'd0;
    assign aw__prot         = 3'd0;

    assign w__valid         = w_valid_q;
    assign w__id            = exp_id;
    assign w__data          = wdata_q;
    assign w__strb          = strb_q;
    assign w__last          = 1'b1;

    assign status__id_error = id_err_q;
    assign status__timeouts = timeouts_q;

endmodule

// File: tb/tb_lw_axi_reg_sequencer.sv
// Directed bench for lw_axi_reg_sequencer: table of zero-wait transfers plus
// hand sequences for skewed write, contention, timeout/drain and mid-transfer reset.
module tb_lw_axi_reg_sequencer;

    localparam logic [11:0] ID_BASE = 12'h0A0;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0__valid, req0__write, req0_ack;
    logic [31:0] req0__addr, req0__data;
    logic [3:0]  req0__strb;
    logic        req1__valid, req1__write, req1_ack;
    logic [31:0] req1__addr, req1__data;
    logic [3:0]  req1__strb;
    logic        resp0__valid, resp1__valid;
    logic [31:0] resp0__data, resp1__data;
    logic [1:0]  resp0__resp, resp1__resp;
    logic        ar__valid, arready, aw__valid, awready;
    logic [31:0] ar__addr, aw__addr;
    logic [11:0] ar__id, aw__id;
    logic [3:0]  ar__len, aw__len, ar__cache, aw__cache;
    logic [2:0]  ar__size, aw__size, ar__prot, aw__prot;
    logic [1:0]  ar__burst, aw__burst, ar__lock, aw__lock;
    logic        w__valid, w__last, wready;
    logic [11:0] w__id;
    logic [31:0] w__data;
    logic [3:0]  w__strb;
    logic        r__valid, r__last, rready;
    logic [11:0] r__id;
    logic [31:0] r__data;
    logic [1:0]  r__resp;
    logic        b__valid, bready;
    logic [11:0] b__id;
    logic [1:0]  b__resp;
    logic        status__busy, status__id_error;
    logic [7:0]  status__timeouts;

    always #5 clk = ~clk;

    lw_axi_reg_sequencer #(.ID_BASE(ID_BASE), .TIMEOUT(8)) dut (
        .clk(clk), .reset(reset),
        .req0__valid(req0__valid), .req0__write(req0__write), .req0__addr(req0__addr),
        .req0__data(req0__data), .req0__strb(req0__strb), .req0_ack(req0_ack),
        .req1__valid(req1__valid), .req1__write(req1__write), .req1__addr(req1__addr),
        .req1__data(req1__data), .req1__strb(req1__strb), .req1_ack(req1_ack),
        .resp0__valid(resp0__valid), .resp0__data(resp0__data), .resp0__resp(resp0__resp),
        .resp1__valid(resp1__valid), .resp1__data(resp1__data), .resp1__resp(resp1__resp),
        .ar__valid(ar__valid), .ar__addr(ar__addr), .ar__id(ar__id), .ar__len(ar__len),
        .ar__size(ar__size), .ar__burst(ar__burst), .ar__lock(ar__lock), .ar__cache(ar__cache),
        .ar__prot(ar__prot), .arready(arready),
        .aw__valid(aw__valid), .aw__addr(aw__addr), .aw__id(aw__id), .aw__len(aw__len),
        .aw__size(aw__size), .aw__burst(aw__burst), .aw__lock(aw__lock), .aw__cache(aw__cache),
        .aw__prot(aw__prot), .awready(awready),
        .w__valid(w__valid), .w__id(w__id), .w__data(w__data), .w__strb(w__strb),
        .w__last(w__last), .wready(wready),
        .r__valid(r__valid), .r__id(r__id), .r__data(r__data), .r__resp(r__resp),
        .r__last(r__last), .rready(rready),
        .b__valid(b__valid), .b__id(b__id), .b__resp(b__resp), .bready(bready),
        .status__busy(status__busy), .status__id_error(status__id_error),
        .status__timeouts(status__timeouts)
    );

    typedef struct {
        logic        idx;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [31:0] rdata;
        logic [1:0]  resp;
        logic        bad_id;
        logic [31:0] exp_data;
        logic [1:0]  exp_resp;
    } vec_t;

    int   n_checks = 0;
    int   n_err = 0;
    int   p0 = 0, p1 = 0;
    int   exp_p0 = 0, exp_p1 = 0;
    logic exp_id_err = 1'b0;

    always @(negedge clk) begin
        if (resp0__valid) p0++;
        if (resp1__valid) p1++;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input logic idx, input logic wr, input logic [31:0] addr,
                             input logic [31:0] data, input logic [3:0] strb);
        if (idx) begin
            req1__valid = 1'b1; req1__write = wr; req1__addr = addr;
            req1__data = data; req1__strb = strb;
        end else begin
            req0__valid = 1'b1; req0__write = wr; req0__addr = addr;
            req0__data = data; req0__strb = strb;
        end
    endtask

    // Zero-wait slave transfer: ack at T, addr at T+1, R/B at T+2, response at T+3.
    task automatic run_vec(input string tag, input vec_t v);
        logic [11:0] eid;
        logic [31:0] amask;
        eid = ID_BASE | {11'd0, v.idx};
        amask = {v.addr[31:2], 2'b00};
        drive_req(v.idx, v.wr, v.addr, v.wdata, v.strb);
        #1;
        chk({tag, "_ack"}, {req1_ack, req0_ack}, v.idx ? 2'b10 : 2'b01);
        cyc();
        if (v.idx) req1__valid = 1'b0; else req0__valid = 1'b0;
        if (!v.wr) begin
            chk({tag, "_avalid"}, {ar__valid, aw__valid, w__valid}, 3'b100);
            chk({tag, "_araddr"}, {ar__id, ar__addr}, {eid, amask});
            chk({tag, "_arfields"}, {ar__len, ar__size, ar__burst, ar__lock, ar__cache, ar__prot},
                {4'd0, 3'd2, 2'd1, 2'd0, 4'd0, 3'd0});
            arready = 1'b1;
        end else begin
            chk({tag, "_avalid"}, {ar__valid, aw__valid, w__valid}, 3'b011);
            chk({tag, "_awaddr"}, {aw__id, aw__addr}, {eid, amask});
            chk({tag, "_wdata"}, {w__id, w__strb, w__last, w__data}, {eid, v.strb, 1'b1, v.wdata});
            chk({tag, "_awfields"}, {aw__len, aw__size, aw__burst}, {4'd0, 3'd2, 2'd1});
            awready = 1'b1;
            wready = 1'b1;
        end
        cyc();
        arready = 1'b0; awready = 1'b0; wready = 1'b0;
        chk({tag, "_rbready"}, {ar__valid, aw__valid, w__valid, rready, bready},
            v.wr ? 5'b00001 : 5'b00010);
        if (!v.wr) begin
            r__valid = 1'b1; r__id = v.bad_id ? 12'h7FF : eid;
            r__data = v.rdata; r__resp = v.resp; r__last = 1'b1;
        end else begin
            b__valid = 1'b1; b__id = v.bad_id ? 12'h7FF : eid; b__resp = v.resp;
        end
        cyc();
        r__valid = 1'b0; b__valid = 1'b0;
        exp_id_err = exp_id_err | v.bad_id;
        if (v.idx) exp_p1++; else exp_p0++;
        chk({tag, "_respvalid"}, {resp1__valid, resp0__valid}, v.idx ? 2'b10 : 2'b01);
        chk({tag, "_respdata"}, {v.idx ? resp1__data : resp0__data, v.idx ? resp1__resp : resp0__resp},
            {v.exp_data, v.exp_resp});
        chk({tag, "_iderr"}, status__id_error, exp_id_err);
        cyc();
        chk({tag, "_done"}, {resp1__valid, resp0__valid, status__busy}, 3'b000);
    endtask

    vec_t vecs[5];

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int gcnt0, gcnt1, ngr, last_t;
        logic [11:0] lat_id;

        vecs[0] = '{idx: 1'b0, wr: 1'b0, addr: 32'h104, wdata: 32'h0, strb: 4'h0, rdata: 32'hDEADBEEF,
                    resp: 2'b00, bad_id: 1'b0, exp_data: 32'hDEADBEEF, exp_resp: 2'b00};
        vecs[1] = '{idx: 1'b1, wr: 1'b1, addr: 32'h8, wdata: 32'h0BADF00D, strb: 4'h5, rdata: 32'h0,
                    resp: 2'b01, bad_id: 1'b0, exp_data: 32'h0, exp_resp: 2'b01};
        vecs[2] = '{idx: 1'b0, wr: 1'b1, addr: 32'h42, wdata: 32'hA5A55A5A, strb: 4'h3, rdata: 32'h0,
                    resp: 2'b00, bad_id: 1'b0, exp_data: 32'h0, exp_resp: 2'b00};
        vecs[3] = '{idx: 1'b0, wr: 1'b0, addr: 32'h7FC, wdata: 32'h0, strb: 4'h0, rdata: 32'h55AA55AA,
                    resp: 2'b00, bad_id: 1'b1, exp_data: 32'h55AA55AA, exp_resp: 2'b00};
        vecs[4] = '{idx: 1'b1, wr: 1'b0, addr: 32'h203, wdata: 32'h0, strb: 4'h0, rdata: 32'hCAFEF00D,
                    resp: 2'b10, bad_id: 1'b0, exp_data: 32'hCAFEF00D, exp_resp: 2'b10};

        reset = 1'b1;
        req0__valid = 1'b1; req0__write = 1'b0; req0__addr = 32'h0; req0__data = 32'h0; req0__strb = 4'h0;
        req1__valid = 1'b0; req1__write = 1'b0; req1__addr = 32'h0; req1__data = 32'h0; req1__strb = 4'h0;
        arready = 1'b0; awready = 1'b0; wready = 1'b0;
        r__valid = 1'b0; r__id = 12'h0; r__data = 32'h0; r__resp = 2'b00; r__last = 1'b0;
        b__valid = 1'b0; b__id = 12'h0; b__resp = 2'b00;
        repeat (3) cyc();
        chk("reset_ctrl", {req1_ack, req0_ack, ar__valid, aw__valid, w__valid, rready, bready,
                           resp0__valid, resp1__valid, status__busy}, 10'd0);
        chk("reset_status", {status__id_error, status__timeouts, resp0__data, resp0__resp}, 43'd0);
        req0__valid = 1'b0;
        reset = 1'b0;
        cyc();

        foreach (vecs[i]) run_vec($sformatf("vec%0d", i), vecs[i]);
        chk("vec_pulses", {p0[15:0], p1[15:0]}, {exp_p0[15:0], exp_p1[15:0]});

        // Write with wready three cycles ahead of awready.
        drive_req(1'b1, 1'b1, 32'h8, 32'h12345678, 4'hF);
        #1;
        chk("skew_ack", {req1_ack, req0_ack}, 2'b10);
        cyc();
        req1__valid = 1'b0;
        chk("skew_t1", {aw__valid, w__valid, bready}, 3'b110);
        wready = 1'b1;
        cyc();
        wready = 1'b0;
        chk("skew_t2", {aw__valid, w__valid, bready}, 3'b100);
        cyc();
        chk("skew_t3", {aw__valid, w__valid, bready}, 3'b100);
        cyc();
        chk("skew_t4", {aw__valid, w__valid, bready}, 3'b100);
        awready = 1'b1;
        cyc();
        awready = 1'b0;
        chk("skew_t5", {aw__valid, w__valid, bready}, 3'b001);
        b__valid = 1'b1; b__id = ID_BASE | 12'd1; b__resp = 2'b00;
        cyc();
        b__valid = 1'b0;
        exp_p1++;
        chk("skew_resp", {resp1__valid, resp0__valid, resp1__data, resp1__resp}, {2'b10, 32'h0, 2'b00});
        cyc();
        chk("skew_done", status__busy, 1'b0);

        // Contention: both hold valid, two reads each.
        drive_req(1'b0, 1'b0, 32'h300, 32'h0, 4'h0);
        drive_req(1'b1, 1'b0, 32'h400, 32'h0, 4'h0);
        gcnt0 = 0; gcnt1 = 0; ngr = 0; last_t = 0; lat_id = 12'h0;
        for (int c = 0; c < 40; c++) begin
            if (gcnt0 == 2) req0__valid = 1'b0;
            if (gcnt1 == 2) req1__valid = 1'b0;
            arready = ar__valid;
            if (ar__valid) lat_id = ar__id;
            r__valid = rready; r__id = lat_id; r__data = 32'h1000 + c; r__resp = 2'b00;
            #1;
            if (req0_ack || req1_ack) begin
                chk($sformatf("cont_grant%0d", ngr), {req1_ack, req0_ack}, (ngr % 2 == 1) ? 2'b10 : 2'b01);
                chk($sformatf("cont_idle%0d", ngr), status__busy, 1'b0);
                if (ngr > 0) chk($sformatf("cont_period%0d", ngr), c - last_t, 4);
                last_t = c;
                ngr++;
                if (req1_ack) gcnt1++; else gcnt0++;
            end
            cyc();
        end
        arready = 1'b0; r__valid = 1'b0;
        exp_p0 += 2; exp_p1 += 2;
        chk("cont_count", ngr, 4);
        chk("cont_pulses", {p0[15:0], p1[15:0]}, {exp_p0[15:0], exp_p1[15:0]});
        chk("cont_iderr", status__id_error, exp_id_err);

        // Silent slave: timeout after 8 cycles in RD_DATA, then drain a late beat.
        drive_req(1'b0, 1'b0, 32'h500, 32'h0, 4'h0);
        #1;
        chk("to_ack", {req1_ack, req0_ack}, 2'b01);
        cyc();
        req0__valid = 1'b0;
        arready = 1'b1;
        cyc();
        arready = 1'b0;
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("to_wait%0d", k), {rready, resp0__valid}, 2'b10);
            cyc();
        end
        exp_p0++;
        chk("to_resp", {resp0__valid, resp0__resp, resp0__data}, {1'b1, 2'b11, 32'h0});
        chk("to_count", status__timeouts, 8'd1);
        drive_req(1'b1, 1'b0, 32'h600, 32'h0, 4'h0);
        #1;
        chk("to_noack_respond", {req1_ack, req0_ack}, 2'b00);
        for (int k = 0; k < 4; k++) begin
            cyc();
            if (k == 3) begin
                r__valid = 1'b1; r__id = ID_BASE; r__data = 32'hBAD0BAD0; r__resp = 2'b00;
            end
            #1;
            chk($sformatf("to_drain%0d", k), {rready, status__busy, resp0__valid, req1_ack}, 4'b1100);
        end
        cyc();
        r__valid = 1'b0;
        chk("to_pulses", {p0[15:0], p1[15:0]}, {exp_p0[15:0], exp_p1[15:0]});
        run_vec("after_to", '{idx: 1'b1, wr: 1'b0, addr: 32'h600, wdata: 32'h0, strb: 4'h0,
                              rdata: 32'h600D600D, resp: 2'b00, bad_id: 1'b0,
                              exp_data: 32'h600D600D, exp_resp: 2'b00});

        // Reset in the middle of a write.
        drive_req(1'b0, 1'b1, 32'h20, 32'hFEEDFACE, 4'hF);
        #1;
        chk("rst_ack", {req1_ack, req0_ack}, 2'b01);
        cyc();
        req0__valid = 1'b0;
        chk("rst_pre", {aw__valid, w__valid, status__busy}, 3'b111);
        reset = 1'b1;
        cyc();
        chk("rst_valids", {ar__valid, aw__valid, w__valid, rready, bready,
                           resp0__valid, resp1__valid, status__busy}, 8'd0);
        chk("rst_status", {status__id_error, status__timeouts}, 9'd0);
        chk("rst_data", {resp0__data, resp0__resp, resp1__resp}, 36'd0);
        chk("rst_data1", resp1__data, 32'd0);
        reset = 1'b0;
        exp_id_err = 1'b0;
        cyc();
        run_vec("post_rst", '{idx: 1'b0, wr: 1'b0, addr: 32'h44, wdata: 32'h0, strb: 4'h0,
                              rdata: 32'h13579BDF, resp: 2'b00, bad_id: 1'b0,
                              exp_data: 32'h13579BDF, exp_resp: 2'b00});
        chk("final_pulses", {p0[15:0], p1[15:0]}, {exp_p0[15:0], exp_p1[15:0]});

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
